// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

    // Register-file address width (x0..x31).
    localparam int unsigned RegAddrW = 5;

    // Controller FSM; encodings are visible on ctrl_state for debug.
    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StErr     = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    // Next count: clear wins, otherwise increment until all-ones.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline controller: memory wait-state freeze with timeout,
// branch flush, load-use stall, and stall/flush performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RegAddrW-1:0] id_rs1_addr,
    input  logic [RegAddrW-1:0] id_rs2_addr,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic                ex_MemRead,
    input  logic [RegAddrW-1:0] ex_rd_addr,
    input  logic                ex_branch_taken,
    input  logic                mem_MemRead,
    input  logic                mem_MemWrite,
    input  logic                dmem_ready,
    output logic                dmem_req,
    output logic                pc_en,
    output logic                if_id_en,
    output logic                id_ex_en,
    output logic                ex_mem_en,
    output logic                mem_wb_en,
    output logic                if_id_flush,
    output logic                id_ex_flush,
    output logic                mem_wb_bubble,
    output logic                mem_err,
    output logic [1:0]          ctrl_state,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [CNT_W-1:0]    flush_count
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e      state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [WaitW-1:0] wait_inc;
    logic             mem_err_q, mem_err_d;

    logic mem_access;
    logic freeze;
    logic load_use;
    logic branch_flush;
    logic timeout;
    logic stall_inc;
    logic flush_inc;
    logic cnt_clear;

    assign mem_access = mem_MemRead | mem_MemWrite;
    // ERR never freezes; it has its own all-quiet output set.
    assign freeze     = mem_access & ~dmem_ready & (state_q != StErr);
    assign load_use   = ex_MemRead && (ex_rd_addr != '0) &&
                        ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                         (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    assign wait_inc   = wait_cnt_q + WaitW'(1);
    assign timeout    = (wait_inc == WaitW'(MEM_TIMEOUT));

    // Outputs and next state; priority ERR > freeze > branch > load-use > normal.
    always_comb begin
        dmem_req      = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        branch_flush  = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_err_d     = mem_err_q;

        if (rst) begin
            case (state_q)
                StRun, StMemWait: begin
                    dmem_req = mem_access;
                    if (freeze) begin
                        mem_wb_bubble = 1'b1;
                    end else if (ex_branch_taken) begin
                        branch_flush = 1'b1;
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                    end else if (load_use) begin
                        // Hold PC and IF/ID, push a bubble into EX.
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b00111;
                        id_ex_flush = 1'b1;
                    end else begin
                        {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en} = 5'b11111;
                    end

                    if (state_q == StRun) begin
                        if (freeze) begin
                            state_d    = StMemWait;
                            wait_cnt_d = '0;
                        end
                    end else if (!freeze) begin
                        state_d = StRun;
                    end else if (timeout) begin
                        state_d   = StErr;
                        mem_err_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_inc;
                    end
                end
                default: begin
                    // ERR (and the unused encoding) park quietly until reset.
                    state_d   = StErr;
                    mem_err_d = 1'b1;
                end
            endcase
        end
    end

    // State, wait counter and sticky error, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err    = mem_err_q;
    assign ctrl_state = state_q;

    assign cnt_clear = ~rst;
    assign stall_inc = rst & ~pc_en & (state_q != StErr);
    assign flush_inc = rst & branch_flush;

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .inc   (stall_inc),
        .clear (cnt_clear),
        .count (stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .inc   (flush_inc),
        .clear (cnt_clear),
        .count (flush_count)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a scoreboard of expected controls/counters.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic       id_uses_rs1, id_uses_rs2, ex_MemRead, ex_branch_taken;
    logic       mem_MemRead, mem_MemWrite, dmem_ready;

    logic        dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush, mem_wb_bubble, mem_err;
    logic [1:0]  ctrl_state;
    logic [31:0] stall_cycles, flush_count;

    logic        s_dmem_req, s_pc_en, s_if_id_en, s_id_ex_en, s_ex_mem_en, s_mem_wb_en;
    logic        s_if_id_flush, s_id_ex_flush, s_mem_wb_bubble, s_mem_err;
    logic [1:0]  s_ctrl_state;
    logic [3:0]  s_stall_cycles, s_flush_count;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_MemRead      (ex_MemRead),
        .ex_rd_addr      (ex_rd_addr),
        .ex_branch_taken (ex_branch_taken),
        .mem_MemRead     (mem_MemRead),
        .mem_MemWrite    (mem_MemWrite),
        .dmem_ready      (dmem_ready),
        .dmem_req        (dmem_req),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .mem_wb_bubble   (mem_wb_bubble),
        .mem_err         (mem_err),
        .ctrl_state      (ctrl_state),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    // Narrow-counter, long-timeout instance for the saturation check.
    pipeline_ctrl #(
        .MEM_TIMEOUT (64),
        .CNT_W       (4)
    ) dut_sat (
        .clk             (clk),
        .rst             (rst),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_MemRead      (ex_MemRead),
        .ex_rd_addr      (ex_rd_addr),
        .ex_branch_taken (ex_branch_taken),
        .mem_MemRead     (mem_MemRead),
        .mem_MemWrite    (mem_MemWrite),
        .dmem_ready      (dmem_ready),
        .dmem_req        (s_dmem_req),
        .pc_en           (s_pc_en),
        .if_id_en        (s_if_id_en),
        .id_ex_en        (s_id_ex_en),
        .ex_mem_en       (s_ex_mem_en),
        .mem_wb_en       (s_mem_wb_en),
        .if_id_flush     (s_if_id_flush),
        .id_ex_flush     (s_id_ex_flush),
        .mem_wb_bubble   (s_mem_wb_bubble),
        .mem_err         (s_mem_err),
        .ctrl_state      (s_ctrl_state),
        .stall_cycles    (s_stall_cycles),
        .flush_count     (s_flush_count)
    );

    // ctl layout: {pc,if_id,id_ex,ex_mem,mem_wb, fl_if_id, fl_id_ex, bubble, req, err, state[1:0]}
    typedef struct packed {
        logic [11:0] ctl;
        logic [31:0] stall;
        logic [31:0] flush;
    } exp_t;

    exp_t        sb[$];
    int          total  = 0;
    int          passes = 0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;
    logic [11:0] obs_ctl;

    assign obs_ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush,
                      id_ex_flush, mem_wb_bubble, dmem_req, mem_err, ctrl_state};

    function automatic logic [11:0] mk(input logic [4:0] en, input logic fi, input logic fe,
                                       input logic bub, input logic req, input logic err,
                                       input logic [1:0] st);
        return {en, fi, fe, bub, req, err, st};
    endfunction

    localparam logic [11:0] Norm = 12'b11111_000_00_00;

    task automatic idle_inputs();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_MemRead = 1'b0;
        ex_branch_taken = 1'b0; mem_MemRead = 1'b0; mem_MemWrite = 1'b0;
        dmem_ready = 1'b0;
    endtask

    // One cycle: push expectation for the driven inputs, check outputs, clock, check counters.
    task automatic step(input string tag, input logic [11:0] exp);
        exp_t e;
        if (!rst) begin
            m_stall = '0;
            m_flush = '0;
        end else if (exp[1:0] != 2'd2) begin
            if (!exp[11]) m_stall = m_stall + 32'd1;
            if (exp[6])   m_flush = m_flush + 32'd1;
        end
        sb.push_back('{ctl: exp, stall: m_stall, flush: m_flush});
        #1;
        e = sb.pop_front();
        total++;
        assert (obs_ctl === e.ctl) passes++;
        else $error("FAIL %s ctl: got %b want %b", tag, obs_ctl, e.ctl);
        @(posedge clk);
        #1;
        total++;
        assert (stall_cycles === e.stall) passes++;
        else $error("FAIL %s stall_cycles: got %0d want %0d", tag, stall_cycles, e.stall);
        total++;
        assert (flush_count === e.flush) passes++;
        else $error("FAIL %s flush_count: got %0d want %0d", tag, flush_count, e.flush);
    endtask

    initial begin
        exp_t e;
        rst = 1'b0;
        idle_inputs();
        mem_MemRead = 1'b1;
        @(posedge clk);
        #1;
        step("reset", mk(5'b00000, 0, 0, 0, 0, 0, 2'd0));
        rst = 1'b1;
        mem_MemRead = 1'b0;
        step("normal", Norm);

        // Load-use on rs2, then the bubble has moved on.
        ex_MemRead = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
        step("load_use_rs2", mk(5'b00111, 0, 1, 0, 0, 0, 2'd0));
        ex_MemRead = 1'b0;
        step("after_load_use", Norm);
        ex_MemRead = 1'b1; ex_rd_addr = 5'd0; id_rs2_addr = 5'd0;
        step("x0_no_stall", Norm);
        idle_inputs();
        ex_MemRead = 1'b1; ex_rd_addr = 5'd7; id_rs1_addr = 5'd7; id_uses_rs1 = 1'b1;
        step("load_use_rs1", mk(5'b00111, 0, 1, 0, 0, 0, 2'd0));
        id_uses_rs1 = 1'b0;
        step("match_unused", Norm);

        // Branch together with a load-use hazard: flush only.
        idle_inputs();
        ex_MemRead = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
        ex_branch_taken = 1'b1;
        step("branch_hazard", mk(5'b11111, 1, 1, 0, 0, 0, 2'd0));
        idle_inputs();
        step("post_branch", Norm);

        // Three wait states; a branch during freeze must not flush.
        mem_MemRead = 1'b1;
        step("wait_run", mk(5'b00000, 0, 0, 1, 1, 0, 2'd0));
        ex_branch_taken = 1'b1;
        step("wait_1", mk(5'b00000, 0, 0, 1, 1, 0, 2'd1));
        ex_branch_taken = 1'b0;
        step("wait_2", mk(5'b00000, 0, 0, 1, 1, 0, 2'd1));
        dmem_ready = 1'b1;
        step("wait_ready", mk(5'b11111, 0, 0, 0, 1, 0, 2'd1));
        idle_inputs();
        step("wait_done", Norm);

        // Zero-wait write.
        mem_MemWrite = 1'b1; dmem_ready = 1'b1;
        step("zero_wait", mk(5'b11111, 0, 0, 0, 1, 0, 2'd0));
        dmem_ready = 1'b0;

        // Timeout: 1 RUN cycle plus 4 MEM_WAIT cycles, then ERR.
        step("to_run", mk(5'b00000, 0, 0, 1, 1, 0, 2'd0));
        for (int i = 0; i < 4; i++) step("to_wait", mk(5'b00000, 0, 0, 1, 1, 0, 2'd1));
        ex_branch_taken = 1'b1;
        ex_MemRead = 1'b1; ex_rd_addr = 5'd5; id_rs2_addr = 5'd5; id_uses_rs2 = 1'b1;
        step("err_1", mk(5'b00000, 0, 0, 0, 0, 1, 2'd2));
        step("err_2", mk(5'b00000, 0, 0, 0, 0, 1, 2'd2));
        rst = 1'b0;
        step("err_reset", mk(5'b00000, 0, 0, 0, 0, 1, 2'd2));
        rst = 1'b1;
        idle_inputs();
        step("after_err", Norm);

        // Reset mid-wait drops the request immediately.
        mem_MemRead = 1'b1;
        step("rw_run", mk(5'b00000, 0, 0, 1, 1, 0, 2'd0));
        step("rw_wait", mk(5'b00000, 0, 0, 1, 1, 0, 2'd1));
        rst = 1'b0;
        step("rw_reset", mk(5'b00000, 0, 0, 0, 0, 0, 2'd1));
        rst = 1'b1;
        idle_inputs();
        step("rw_after", Norm);

        // Saturation on the 4-bit instance under a continuous freeze.
        rst = 1'b0;
        step("sat_reset", mk(5'b00000, 0, 0, 0, 0, 0, 2'd0));
        rst = 1'b1;
        mem_MemRead = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            sb.push_back('{ctl: 12'd0, stall: (i > 15) ? 32'd15 : 32'(i), flush: 32'd0});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            assert (s_stall_cycles === e.stall[3:0]) passes++;
            else $error("FAIL sat_%0d stall_cycles: got %0d want %0d", i, s_stall_cycles,
                        e.stall[3:0]);
        end
        total++;
        assert (s_ctrl_state === 2'd1) passes++;
        else $error("FAIL sat_state: got %0d want 1", s_ctrl_state);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
